// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle between the VGA timing generator (master) and the pattern stages (slave).
interface vga_timing_gen_if;
  logic        pix_en;
  logic        hsync;
  logic        vsync;
  logic        display_on;
  logic [11:0] hpos;
  logic [11:0] vpos;
  logic        line_start;
  logic        frame_start;

  modport master (
    input  pix_en,
    output hsync, vsync, display_on, hpos, vpos, line_start, frame_start
  );

  modport slave (
    output pix_en,
    input  hsync, vsync, display_on, hpos, vpos, line_start, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel counters with registered sync, blanking and strobe outputs,
// all decoded from the position being loaded so they always describe the presented pixel.
module vga_timing_gen #(
  parameter int H_ACTIVE = 1024,
  parameter int H_FP     = 24,
  parameter int H_SYNC   = 136,
  parameter int H_BP     = 160,
  parameter int V_ACTIVE = 768,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 29,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input logic              clk,
  input logic              reset,
  vga_timing_gen_if.master vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  generate
    if (H_TOTAL > 4096 || V_TOTAL > 4096) begin : g_geometry_too_large
      $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 4096");
    end
  endgenerate

  localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);

  // Boundaries are 13 bits so a 4096-wide geometry still compares correctly.
  localparam logic [12:0] H_ACT_END = 13'(H_ACTIVE);
  localparam logic [12:0] HS_BEGIN  = 13'(H_ACTIVE + H_FP);
  localparam logic [12:0] HS_END    = 13'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [12:0] V_ACT_END = 13'(V_ACTIVE);
  localparam logic [12:0] VS_BEGIN  = 13'(V_ACTIVE + V_FP);
  localparam logic [12:0] VS_END    = 13'(V_ACTIVE + V_FP + V_SYNC);

  logic [11:0] hpos_q, hpos_d;
  logic [11:0] vpos_q, vpos_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        display_on_q, display_on_d;
  logic        line_start_q, line_start_d;
  logic        frame_start_q, frame_start_d;

  logic [12:0] hExt;
  logic [12:0] vExt;
  logic        hsActive;
  logic        vsActive;

  always_comb begin
    hpos_d        = hpos_q;
    vpos_d        = vpos_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;

    if (vga.pix_en) begin
      if (hpos_q == H_LAST) begin
        hpos_d       = '0;
        line_start_d = 1'b1;
        if (vpos_q == V_LAST) begin
          vpos_d        = '0;
          frame_start_d = 1'b1;
        end else begin
          vpos_d = vpos_q + 12'd1;
        end
      end else begin
        hpos_d = hpos_q + 12'd1;
      end
    end

    // Decoding the held position on idle edges reproduces the current outputs, so they hold.
    hExt         = {1'b0, hpos_d};
    vExt         = {1'b0, vpos_d};
    hsActive     = (hExt >= HS_BEGIN) && (hExt < HS_END);
    vsActive     = (vExt >= VS_BEGIN) && (vExt < VS_END);
    display_on_d = (hExt < H_ACT_END) && (vExt < V_ACT_END);
    hsync_d      = hsActive ? HS_POL : ~HS_POL;
    vsync_d      = vsActive ? VS_POL : ~VS_POL;
  end

  // Reset parks on the last blanking pixel so the first enabled edge lands on (0,0).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hpos_q        <= H_LAST;
      vpos_q        <= V_LAST;
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      display_on_q  <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hpos_q        <= hpos_d;
      vpos_q        <= vpos_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      display_on_q  <= display_on_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vga.hpos        = hpos_q;
  assign vga.vpos        = vpos_q;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.display_on  = display_on_q;
  assign vga.line_start  = line_start_q;
  assign vga.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default-geometry instance plus a tiny-geometry instance so whole
// frames fit in the run, both checked every cycle against a linear pixel-index model.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [11:0] hpos;
    logic [11:0] vpos;
    logic        disp;
    logic        hs;
    logic        vs;
    logic        ls;
    logic        fs;
  } obs_t;

  typedef struct {
    bit   en;
    obs_t exp;
  } vec_t;

  localparam int A_HT  = 1344;
  localparam int A_VT  = 806;
  localparam int A_TOT = A_HT * A_VT;
  localparam int B_HT  = 25;
  localparam int B_VT  = 16;
  localparam int B_TOT = B_HT * B_VT;

  logic clk;
  logic reset;

  vga_timing_gen_if vgaA ();
  vga_timing_gen_if vgaB ();

  vga_timing_gen uDutA (
    .clk   (clk),
    .reset (reset),
    .vga   (vgaA)
  );

  vga_timing_gen #(
    .H_ACTIVE (16), .H_FP (2), .H_SYNC (3), .H_BP (4),
    .V_ACTIVE (10), .V_FP (1), .V_SYNC (2), .V_BP (3),
    .HS_POL   (1'b0), .VS_POL (1'b0)
  ) uDutB (
    .clk   (clk),
    .reset (reset),
    .vga   (vgaB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int pA, pB;
  bit lsA, fsA, lsB, fsB;
  int cntA, cntB;
  bit haveA, haveB;

  function automatic obs_t mk(int h, int v, bit de, bit hs, bit vs, bit ls, bit fs);
    obs_t o;
    o.hpos = 12'(h);
    o.vpos = 12'(v);
    o.disp = de;
    o.hs   = hs;
    o.vs   = vs;
    o.ls   = ls;
    o.fs   = fs;
    return o;
  endfunction

  // Position is a single pixel index into the frame; h/v fall out of div/mod.
  function automatic obs_t modelDecode(int p, int hAct, int hFp, int hSyn, int hTot,
                                       int vAct, int vFp, int vSyn, bit ls, bit fs);
    int h = p % hTot;
    int v = p / hTot;
    bit hsOn = (h >= hAct + hFp) && (h < hAct + hFp + hSyn);
    bit vsOn = (v >= vAct + vFp) && (v < vAct + vFp + vSyn);
    return mk(h, v, (h < hAct) && (v < vAct), !hsOn, !vsOn, ls, fs);
  endfunction

  function automatic obs_t expA();
    return modelDecode(pA, 1024, 24, 136, A_HT, 768, 3, 6, lsA, fsA);
  endfunction

  function automatic obs_t expB();
    return modelDecode(pB, 16, 2, 3, B_HT, 10, 1, 2, lsB, fsB);
  endfunction

  function automatic obs_t sampleA();
    return {vgaA.hpos, vgaA.vpos, vgaA.display_on, vgaA.hsync, vgaA.vsync,
            vgaA.line_start, vgaA.frame_start};
  endfunction

  function automatic obs_t sampleB();
    return {vgaB.hpos, vgaB.vpos, vgaB.display_on, vgaB.hsync, vgaB.vsync,
            vgaB.line_start, vgaB.frame_start};
  endfunction

  task automatic modelReset();
    pA = A_TOT - 1;
    pB = B_TOT - 1;
    lsA = 0; fsA = 0; lsB = 0; fsB = 0;
    haveA = 0; haveB = 0;
    cntA = 0; cntB = 0;
  endtask

  task automatic modelStep(bit en);
    if (en) begin
      pA  = (pA + 1) % A_TOT;
      pB  = (pB + 1) % B_TOT;
      lsA = (pA % A_HT) == 0;
      fsA = pA == 0;
      lsB = (pB % B_HT) == 0;
      fsB = pB == 0;
      cntA++;
      cntB++;
    end else begin
      lsA = 0; fsA = 0; lsB = 0; fsB = 0;
    end
  endtask

  task automatic compare(input string name, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got h=%0d v=%0d de=%b hs=%b vs=%b ls=%b fs=%b, expected h=%0d v=%0d de=%b hs=%b vs=%b ls=%b fs=%b",
               name, act.hpos, act.vpos, act.disp, act.hs, act.vs, act.ls, act.fs,
               exp.hpos, exp.vpos, exp.disp, exp.hs, exp.vs, exp.ls, exp.fs);
    end
  endtask

  task automatic compareInt(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(bit en);
    @(negedge clk);
    vgaA.pix_en = en;
    vgaB.pix_en = en;
    @(posedge clk);
    #1;
    modelStep(en);
  endtask

  task automatic checkOutput(input string tag);
    compare({tag, "_A"}, sampleA(), expA());
    compare({tag, "_B"}, sampleB(), expB());
    if (vgaA.line_start) begin
      if (haveA) compareInt("line_spacing_A", cntA, A_HT);
      haveA = 1;
      cntA  = 0;
    end
    if (vgaB.frame_start) begin
      if (haveB) compareInt("frame_spacing_B", cntB, B_TOT);
      haveB = 1;
      cntB  = 0;
    end
  endtask

  task automatic runUntilH(int target);
    for (int n = 0; n < 2 * A_HT && (pA % A_HT) != target; n++) begin
      applyStimulus(1'b1);
      checkOutput("seek");
    end
  endtask

  vec_t vecs[8];
  int   spotH[6]  = '{1023, 1024, 1047, 1048, 1183, 1184};
  int   spotDh[6] = '{2'b11, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01};
  bit   pat[4]    = '{1'b1, 1'b0, 1'b0, 1'b1};
  int   patH[4]   = '{101, 101, 101, 102};
  int   wrapH[4]  = '{0, 0, 0, 1};
  int   wrapLs[4] = '{1, 0, 0, 0};
  obs_t resetA;

  initial begin
    resetA  = mk(1343, 805, 0, 1, 1, 0, 0);
    vecs[0] = '{1'b1, mk(0, 0, 1, 1, 1, 1, 1)};
    vecs[1] = '{1'b1, mk(1, 0, 1, 1, 1, 0, 0)};
    vecs[2] = '{1'b0, mk(1, 0, 1, 1, 1, 0, 0)};
    vecs[3] = '{1'b0, mk(1, 0, 1, 1, 1, 0, 0)};
    vecs[4] = '{1'b1, mk(2, 0, 1, 1, 1, 0, 0)};
    vecs[5] = '{1'b1, mk(3, 0, 1, 1, 1, 0, 0)};
    vecs[6] = '{1'b0, mk(3, 0, 1, 1, 1, 0, 0)};
    vecs[7] = '{1'b1, mk(4, 0, 1, 1, 1, 0, 0)};

    reset = 1'b1;
    vgaA.pix_en = 1'b0;
    vgaB.pix_en = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    modelReset();
    compare("reset_A", sampleA(), resetA);
    compare("reset_B", sampleB(), expB());
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].en);
      compare($sformatf("vec%0d", i), sampleA(), vecs[i].exp);
      checkOutput($sformatf("vec%0d", i));
    end

    // Line 0 blanking and hsync edges.
    while ((pA % A_HT) != 1200) begin
      applyStimulus(1'b1);
      checkOutput("line0");
      for (int k = 0; k < 6; k++)
        if (pA == spotH[k])
          compareInt($sformatf("spot_h%0d", spotH[k]),
                     int'({vgaA.display_on, vgaA.hsync}), spotDh[k]);
    end

    // Random enables run the big instance past line 11 and the small one through many frames.
    for (int n = 0; n < 18000; n++) begin
      applyStimulus($urandom_range(0, 9) != 0);
      checkOutput("rand");
      if (pA == 11 * A_HT && lsA)
        compareInt("wrap_10_to_11", int'({vgaA.vpos, vgaA.line_start, vgaA.frame_start}),
                   int'({12'd11, 1'b1, 1'b0}));
    end

    runUntilH(100);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(pat[k]);
      checkOutput("pat100");
      compareInt("pat100_hpos", int'(vgaA.hpos), patH[k]);
    end

    runUntilH(1343);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(pat[k]);
      checkOutput("pat1343");
      compareInt("pat1343_hpos", int'(vgaA.hpos), wrapH[k]);
      compareInt("pat1343_ls", int'(vgaA.line_start), wrapLs[k]);
    end

    for (int n = 0; n < 300; n++) begin
      applyStimulus(1'b1);
      checkOutput("pre_reset");
    end

    // Asynchronous reset between edges must show up before the next rising edge.
    @(negedge clk);
    #2;
    vgaA.pix_en = 1'b0;
    vgaB.pix_en = 1'b0;
    reset = 1'b1;
    #1;
    modelReset();
    compare("async_reset_A", sampleA(), resetA);
    compare("async_reset_B", sampleB(), expB());
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(1'b1);
    compare("restart_A", sampleA(), mk(0, 0, 1, 1, 1, 1, 1));
    checkOutput("restart");

    for (int n = 0; n < 500; n++) begin
      applyStimulus($urandom_range(0, 3) != 0);
      checkOutput("tail");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
